// File: rtl/cpu_sequencer.sv
// Four-phase instruction sequencer: FETCH/DECODE/EXECUTE/WRITEBACK with HALT,
// branch-flag latching and a saturating retire counter. Optional SEQ_SINGLE_STEP_EN adds a PAUSE phase.
module cpu_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec_alu_en,
    input  logic             dec_write_en,
    input  logic             dec_halt,
    input  logic             dec_branch,
    input  logic [1:0]       dec_cond,
    input  logic [7:0]       dec_target,
    input  logic             alu_zero,
    input  logic             alu_carry,
    input  logic             step,
    output logic             alu_en,
    output logic             write_en,
    output logic             pc_en,
    output logic             pc_overwrite,
    output logic [7:0]       pc_target,
    output logic             halted,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_WRITEBACK = 3'd3,
        ST_HALTED    = 3'd4,
        ST_PAUSE     = 3'd5
    } state_t;

    state_t           state_r;
    logic             alu_en_r;
    logic             write_en_r;
    logic             pc_en_r;
    logic             pc_overwrite_r;
    logic [7:0]       pc_target_r;
    logic             halted_r;
    logic [CNT_W-1:0] retired_r;
    logic             zero_r;
    logic             carry_r;
    logic             take_s;

    function automatic logic cond_met(input logic [1:0] cond, input logic z, input logic c);
        logic met;
        case (cond)
            2'b00:   met = 1'b1;
            2'b01:   met = z;
            2'b10:   met = c;
            2'b11:   met = ~z;
            default: met = 1'b0;
        endcase
        return met;
    endfunction

    // Branch decision uses the flags held before this instruction's own EXECUTE capture
    always_comb begin
        take_s = dec_branch & cond_met(dec_cond, zero_r, carry_r);
    end

`ifndef SEQ_SINGLE_STEP_EN
    logic unused_step_s;
    assign unused_step_s = step;
`endif

    // Sequencer state, flag register, retire counter and registered strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_FETCH;
            alu_en_r       <= 1'b0;
            write_en_r     <= 1'b0;
            pc_en_r        <= 1'b0;
            pc_overwrite_r <= 1'b0;
            pc_target_r    <= 8'h00;
            halted_r       <= 1'b0;
            retired_r      <= {CNT_W{1'b0}};
            zero_r         <= 1'b0;
            carry_r        <= 1'b0;
        end else begin
            // strobes are decodes of the state being entered, so they default low
            alu_en_r       <= 1'b0;
            write_en_r     <= 1'b0;
            pc_en_r        <= 1'b0;
            pc_overwrite_r <= 1'b0;
            pc_target_r    <= 8'h00;
            case (state_r)
                ST_FETCH: begin
                    state_r <= ST_DECODE;
                end
                ST_DECODE: begin
                    if (dec_halt) begin
                        state_r  <= ST_HALTED;
                        halted_r <= 1'b1;
                    end else begin
                        state_r  <= ST_EXECUTE;
                        alu_en_r <= dec_alu_en;
                    end
                end
                ST_EXECUTE: begin
                    if (dec_alu_en) begin
                        zero_r  <= alu_zero;
                        carry_r <= alu_carry;
                    end else begin
                        zero_r  <= zero_r;
                        carry_r <= carry_r;
                    end
                    state_r        <= ST_WRITEBACK;
                    write_en_r     <= dec_write_en;
                    pc_en_r        <= 1'b1;
                    pc_overwrite_r <= take_s;
                    pc_target_r    <= take_s ? dec_target : 8'h00;
                end
                ST_WRITEBACK: begin
                    if (retired_r != {CNT_W{1'b1}}) begin
                        retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        retired_r <= retired_r;
                    end
`ifdef SEQ_SINGLE_STEP_EN
                    state_r <= ST_PAUSE;
`else
                    state_r <= ST_FETCH;
`endif
                end
                ST_HALTED: begin
                    state_r  <= ST_HALTED;
                    halted_r <= 1'b1;
                end
                ST_PAUSE: begin
`ifdef SEQ_SINGLE_STEP_EN
                    if (step) begin
                        state_r <= ST_FETCH;
                    end else begin
                        state_r <= ST_PAUSE;
                    end
`else
                    state_r <= ST_FETCH;
`endif
                end
                default: begin
                    state_r <= ST_FETCH;
                end
            endcase
        end
    end

    assign alu_en       = alu_en_r;
    assign write_en     = write_en_r;
    assign pc_en        = pc_en_r;
    assign pc_overwrite = pc_overwrite_r;
    assign pc_target    = pc_target_r;
    assign halted       = halted_r;
    assign state        = state_r;
    assign retired      = retired_r;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: per-cycle expected outputs are queued by the
// driver and compared on the falling edge; a CNT_W=2 twin checks counter saturation.
module tb_cpu_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       dec_alu_en = 1'b0, dec_write_en = 1'b0, dec_halt = 1'b0, dec_branch = 1'b0;
    logic [1:0] dec_cond = 2'b00;
    logic [7:0] dec_target = 8'h00;
    logic       alu_zero = 1'b0, alu_carry = 1'b0, step = 1'b0;

    logic        alu_en, write_en, pc_en, pc_overwrite, halted;
    logic [7:0]  pc_target;
    logic [2:0]  state;
    logic [15:0] retired;

    logic        s_alu_en, s_write_en, s_pc_en, s_pc_overwrite, s_halted;
    logic [7:0]  s_pc_target;
    logic [2:0]  s_state;
    logic [1:0]  s_retired;

    always #5 clk = ~clk;

    cpu_sequencer #(.CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .dec_alu_en(dec_alu_en), .dec_write_en(dec_write_en),
        .dec_halt(dec_halt), .dec_branch(dec_branch), .dec_cond(dec_cond),
        .dec_target(dec_target), .alu_zero(alu_zero), .alu_carry(alu_carry), .step(step),
        .alu_en(alu_en), .write_en(write_en), .pc_en(pc_en), .pc_overwrite(pc_overwrite),
        .pc_target(pc_target), .halted(halted), .state(state), .retired(retired)
    );

    cpu_sequencer #(.CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .dec_alu_en(dec_alu_en), .dec_write_en(dec_write_en),
        .dec_halt(dec_halt), .dec_branch(dec_branch), .dec_cond(dec_cond),
        .dec_target(dec_target), .alu_zero(alu_zero), .alu_carry(alu_carry), .step(step),
        .alu_en(s_alu_en), .write_en(s_write_en), .pc_en(s_pc_en), .pc_overwrite(s_pc_overwrite),
        .pc_target(s_pc_target), .halted(s_halted), .state(s_state), .retired(s_retired)
    );

    typedef struct {
        string       name;
        logic [2:0]  st;
        logic        a, w, p, o;
        logic [7:0]  tgt;
        logic        h;
        logic [15:0] ret;
    } exp_t;

    typedef struct {
        logic       alu, we, br;
        logic [1:0] cond;
        logic [7:0] tgt;
        logic       z, c;
        logic       take;
    } instr_t;

    exp_t        q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] ret_exp = 16'd0;

    function automatic exp_t mk(input string name, input logic [2:0] st, input logic a,
                                input logic w, input logic p, input logic o,
                                input logic [7:0] tgt, input logic h, input logic [15:0] ret);
        exp_t e;
        e.name = name; e.st = st; e.a = a; e.w = w; e.p = p; e.o = o;
        e.tgt = tgt; e.h = h; e.ret = ret;
        return e;
    endfunction

    // Scoreboard checker: one expected record per cycle, compared mid-cycle
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_vec++;
            if ({state, alu_en, write_en, pc_en, pc_overwrite, pc_target, halted, retired} !==
                {e.st, e.a, e.w, e.p, e.o, e.tgt, e.h, e.ret}) begin
                n_err++;
                $display("FAIL %s: got st=%0d a=%0b w=%0b p=%0b o=%0b tgt=%h h=%0b ret=%0d, expected st=%0d a=%0b w=%0b p=%0b o=%0b tgt=%h h=%0b ret=%0d",
                         e.name, state, alu_en, write_en, pc_en, pc_overwrite, pc_target, halted, retired,
                         e.st, e.a, e.w, e.p, e.o, e.tgt, e.h, e.ret);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts in a FETCH cycle already queued; ends in the next FETCH cycle, queued
    task automatic run_instr(input instr_t ins, input string name);
        dec_alu_en = ins.alu; dec_write_en = ins.we; dec_branch = ins.br;
        dec_cond = ins.cond; dec_target = ins.tgt; dec_halt = 1'b0;
        tick();
        q.push_back(mk({name, "_dec"}, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, ret_exp));
        tick();
        alu_zero = ins.z; alu_carry = ins.c;
        q.push_back(mk({name, "_exe"}, 3'd2, ins.alu, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, ret_exp));
        tick();
        alu_zero = ~ins.z; alu_carry = ~ins.c;
        q.push_back(mk({name, "_wb"}, 3'd3, 1'b0, ins.we, 1'b1, ins.take,
                       ins.take ? ins.tgt : 8'h00, 1'b0, ret_exp));
        tick();
        ret_exp = ret_exp + 16'd1;
`ifdef SEQ_SINGLE_STEP_EN
        q.push_back(mk({name, "_pause"}, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, ret_exp));
        tick();
`endif
        q.push_back(mk({name, "_fetch"}, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, ret_exp));
    endtask

    task automatic do_reset(input string name);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ret_exp = 16'd0;
        q.push_back(mk(name, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'd0));
    endtask

    instr_t prog[12];

    initial begin
        //            alu   we    br    cond   tgt    z     c     take
        prog[0]  = '{1'b1, 1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 1'b1, 1'b0};
        prog[1]  = '{1'b1, 1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0};
        prog[2]  = '{1'b1, 1'b1, 1'b0, 2'b00, 8'h00, 1'b1, 1'b0, 1'b0};
        prog[3]  = '{1'b0, 1'b0, 1'b1, 2'b01, 8'h2A, 1'b0, 1'b0, 1'b1};
        prog[4]  = '{1'b1, 1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 1'b1, 1'b0};
        prog[5]  = '{1'b1, 1'b0, 1'b1, 2'b01, 8'h2A, 1'b1, 1'b0, 1'b0};
        prog[6]  = '{1'b0, 1'b0, 1'b1, 2'b11, 8'h55, 1'b0, 1'b1, 1'b0};
        prog[7]  = '{1'b0, 1'b0, 1'b1, 2'b00, 8'h10, 1'b0, 1'b0, 1'b1};
        prog[8]  = '{1'b0, 1'b0, 1'b1, 2'b10, 8'h77, 1'b0, 1'b1, 1'b0};
        prog[9]  = '{1'b1, 1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 1'b1, 1'b0};
        prog[10] = '{1'b0, 1'b0, 1'b1, 2'b10, 8'h33, 1'b1, 1'b0, 1'b1};
        prog[11] = '{1'b0, 1'b0, 1'b1, 2'b11, 8'hC3, 1'b1, 1'b1, 1'b1};

`ifdef SEQ_SINGLE_STEP_EN
        step = 1'b1;
`endif
        rst = 1'b1;
        tick();
        do_reset("reset");

        for (int i = 0; i < 12; i++) begin
            logic [1:0] sat_exp;
            run_instr(prog[i], $sformatf("prog%0d", i));
            sat_exp = (i >= 2) ? 2'd3 : 2'(i + 1);
            n_vec++;
            if (s_retired !== sat_exp) begin
                n_err++;
                $display("FAIL sat_retired%0d: got %0d expected %0d", i, s_retired, sat_exp);
            end
        end

        // HALT: absorbing, no strobes, counter frozen
        dec_alu_en = 1'b1; dec_write_en = 1'b1; dec_branch = 1'b0; dec_halt = 1'b1;
        tick();
        q.push_back(mk("halt_dec", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, ret_exp));
        for (int i = 0; i < 21; i++) begin
            tick();
            q.push_back(mk("halted", 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, ret_exp));
        end
        dec_halt = 1'b0;
        do_reset("halt_reset");

        // Reset during EXECUTE aborts the instruction
        dec_alu_en = 1'b1; dec_write_en = 1'b1; dec_branch = 1'b1; dec_cond = 2'b00;
        dec_target = 8'h99;
        tick();
        q.push_back(mk("abort_dec", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'd0));
        tick();
        q.push_back(mk("abort_exe", 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'd0));
        do_reset("abort_reset");
        tick();
        q.push_back(mk("abort_dec2", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'd0));
        dec_branch = 1'b0;
        do_reset("abort_reset2");

`ifdef SEQ_SINGLE_STEP_EN
        // PAUSE holds until step is sampled high
        step = 1'b0;
        dec_alu_en = 1'b0; dec_write_en = 1'b1;
        tick(); q.push_back(mk("ss_dec", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'd0));
        tick(); q.push_back(mk("ss_exe", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'd0));
        tick(); q.push_back(mk("ss_wb", 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 16'd0));
        for (int i = 0; i < 4; i++) begin
            tick(); q.push_back(mk("ss_pause", 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'd1));
        end
        step = 1'b1;
        tick(); q.push_back(mk("ss_fetch", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'd1));
`endif

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
